// File: rtl/lisp_mem_pkg.sv
// Shared widths, the NIL pointer encoding and the cons-cell fetch state type.
package lisp_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] NIL_PTR = 12'h000;

  typedef enum logic [2:0] {
    IDLE,
    REQ_CAR,
    WAIT_CAR,
    REQ_CDR,
    WAIT_CDR,
    FINISH
  } fetch_state_t;

endpackage

// File: rtl/cell_fetch_if.sv
// Request/result and memory-port signals of the cons-cell fetcher.
// The slave side is the fetcher itself; the master side drives requests
// and plays the memory.
interface cell_fetch_if
  import lisp_mem_pkg::*;
();

  logic              start;
  logic [ADDR_W-1:0] ptr_in;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] car_out;
  logic [DATA_W-1:0] cdr_out;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_ready;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output start, ptr_in, mem_data_ready, mem_data,
    input  busy, done, error, car_out, cdr_out, mem_req, mem_addr
  );

  modport slave (
    input  start, ptr_in, mem_data_ready, mem_data,
    output busy, done, error, car_out, cdr_out, mem_req, mem_addr
  );

endinterface

// File: rtl/cell_fetch.sv
// Cons-cell fetcher: reads the car word at a pointer and the cdr word at
// pointer+1 through a one-word-per-request memory port, with a per-word
// response timeout. Every output is a register updated together with the
// state, so each output already reflects the state it accompanies.
module cell_fetch
  import lisp_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic        clk,
  input logic        rst,
  cell_fetch_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value at which one more silent cycle means the limit is reached.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fetch_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] ptr;

  // Fetch sequencer: state, wait counter, latched pointer and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      bus.car_out  <= '0;
      bus.cdr_out  <= '0;
    end else begin
      // Pulses default low; only the transitions below raise them.
      bus.done    <= 1'b0;
      bus.error   <= 1'b0;
      bus.mem_req <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.ptr_in == NIL_PTR) begin
              // NIL has no cell behind it: complete at once with empty words.
              state       <= FINISH;
              bus.done    <= 1'b1;
              bus.car_out <= '0;
              bus.cdr_out <= '0;
            end else begin
              state        <= REQ_CAR;
              ptr          <= bus.ptr_in;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= bus.ptr_in;
            end
          end
        end
        REQ_CAR: begin
          state <= WAIT_CAR;
          cnt   <= '0;
        end
        WAIT_CAR: begin
          // Data is checked first so a response on the limit cycle still wins.
          if (bus.mem_data_ready) begin
            state        <= REQ_CDR;
            bus.car_out  <= bus.mem_data;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= ptr + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= FINISH;
              bus.done  <= 1'b1;
              bus.error <= 1'b1;
            end
          end
        end
        REQ_CDR: begin
          state <= WAIT_CDR;
          cnt   <= '0;
        end
        WAIT_CDR: begin
          bus.done <= bus.mem_data_ready || (cnt == CNT_LAST);
          if (bus.mem_data_ready) begin
            state       <= FINISH;
            bus.cdr_out <= bus.mem_data;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= FINISH;
              bus.error <= 1'b1;
            end
          end
        end
        FINISH: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_fetch.sv
// Randomized bench for cell_fetch: a responding memory with per-word delay
// or silence, and a cycle-level reference model derived from fetch timing.
module tb_cell_fetch;

  localparam int T = 15;

  logic clk;
  logic rst;

  cell_fetch_if bus ();

  cell_fetch #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory image, responder controls and model state.
  logic [15:0] mem [4096];
  int          dly_car;   // -1 = silent, else extra cycles before response
  int          dly_cdr;
  int          req_idx;
  bit          spurious;
  logic [15:0] m_car;
  logic [15:0] m_cdr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers each request after its configured delay.
  initial begin
    int          pend_cnt;
    logic [11:0] pend_addr;
    int          d;
    pend_cnt = 0;
    pend_addr = '0;
    bus.mem_data_ready = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(negedge clk);
      if (pend_cnt == 1) begin
        bus.mem_data_ready = 1'b1;
        bus.mem_data = mem[pend_addr];
      end else begin
        bus.mem_data_ready = spurious;
        bus.mem_data = 16'($urandom);
      end
      if (pend_cnt > 0) pend_cnt--;
      if (bus.mem_req) begin
        d = (req_idx == 0) ? dly_car : dly_cdr;
        pend_cnt = (d < 0) ? 0 : d + 1;
        pend_addr = bus.mem_addr;
        req_idx++;
      end
    end
  end

  function automatic int pick_dly();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 0;
    if (r <= 7) return $urandom_range(1, T + 1);
    if (r == 8) return -1;
    return $urandom_range(T - 1, T);
  endfunction

  // One fetch with START pulsed at edge 0; cycle c is the cycle after edge c-1.
  task automatic run_fetch(input logic [11:0] p, input int dc, input int dd);
    int          e_done, e_nreq, e_req2, got_done, err_stray;
    bit          e_err;
    logic        g_err;
    logic [15:0] e_car, e_cdr, g_car, g_cdr;
    logic [11:0] p1;
    int          req_c[$];
    logic [11:0] req_a[$];

    p1 = p + 12'd1;
    e_car = m_car;
    e_cdr = m_cdr;
    e_req2 = 0;
    e_err = 1'b0;
    if (p == 12'h000) begin
      e_nreq = 0; e_done = 1; e_car = '0; e_cdr = '0;
    end else if (dc < 0 || dc >= T) begin
      e_nreq = 1; e_done = 2 + T; e_err = 1'b1;
    end else begin
      e_car = mem[p]; e_nreq = 2; e_req2 = 3 + dc;
      if (dd < 0 || dd >= T) begin
        e_done = 4 + dc + T; e_err = 1'b1;
      end else begin
        e_cdr = mem[p1]; e_done = 5 + dc + dd;
      end
    end
    m_car = e_car;
    m_cdr = e_cdr;

    @(negedge clk);
    dly_car = dc; dly_cdr = dd; req_idx = 0;
    bus.start = 1'b1; bus.ptr_in = p;
    got_done = -1; err_stray = 0;
    g_err = 1'b0; g_car = '0; g_cdr = '0;
    for (int c = 1; c <= T + 40 && got_done < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        chk("busy_c1", bus.busy, 1);
      end
      if (bus.mem_req) begin
        req_c.push_back(c);
        req_a.push_back(bus.mem_addr);
      end
      if (bus.error && !bus.done) err_stray++;
      if (bus.done) begin
        got_done = c; g_err = bus.error; g_car = bus.car_out; g_cdr = bus.cdr_out;
      end
    end
    chk("done_cycle", got_done, e_done);
    chk("error", g_err, e_err);
    chk("car_out", g_car, e_car);
    chk("cdr_out", g_cdr, e_cdr);
    chk("nreq", req_c.size(), e_nreq);
    if (req_c.size() >= 1) begin
      chk("req1_cycle", req_c[0], 1);
      chk("req1_addr", req_a[0], p);
    end
    if (req_c.size() >= 2) begin
      chk("req2_cycle", req_c[1], e_req2);
      chk("req2_addr", req_a[1], p1);
    end
    chk("stray_error", err_stray, 0);
    @(negedge clk);
    chk("busy_after", bus.busy, 0);
    chk("done_width", bus.done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rp;
    int          cnt_d, cnt_b, cnt_e;
    int          b2b_done[$];
    int          b2b_req[$];

    rst = 1'b1;
    bus.start = 1'b0;
    bus.ptr_in = '0;
    spurious = 1'b0;
    dly_car = 0; dly_cdr = 0; req_idx = 0;
    m_car = '0; m_cdr = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[12'h010] = 16'h1234;
    mem[12'h011] = 16'hBEEF;
    mem[12'hFFF] = 16'h00AA;
    mem[12'h000] = 16'h0000;

    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_car", bus.car_out, 0);
    chk("rst_cdr", bus.cdr_out, 0);
    rst = 1'b0;

    run_fetch(12'h010, 0, 0);
    run_fetch(12'h000, 0, 0);
    run_fetch(12'hFFF, 0, 0);
    run_fetch(12'h234, 0, 0);
    run_fetch(12'h345, 0, -1);
    run_fetch(12'h456, -1, 0);
    run_fetch(12'h567, T - 1, 0);
    run_fetch(12'h678, 0, T);
    run_fetch(12'h789, 2, T - 1);

    // Responses while idle must not touch the results.
    @(negedge clk);
    spurious = 1'b1;
    cnt_d = 0; cnt_b = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) cnt_d++;
      if (bus.busy) cnt_b++;
    end
    spurious = 1'b0;
    chk("idle_rdy_done", cnt_d, 0);
    chk("idle_rdy_busy", cnt_b, 0);
    chk("idle_rdy_car", bus.car_out, m_car);
    chk("idle_rdy_cdr", bus.cdr_out, m_cdr);

    // Reset while waiting for the car word, with START held during reset.
    @(negedge clk);
    dly_car = -1; req_idx = 0;
    bus.start = 1'b1; bus.ptr_in = 12'h0AB;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("wait_busy", bus.busy, 1);
    rst = 1'b1; bus.start = 1'b1; bus.ptr_in = 12'h0CD;
    repeat (2) @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_mem_req", bus.mem_req, 0);
    rst = 1'b0; bus.start = 1'b0;
    spurious = 1'b1;
    cnt_d = 0; cnt_b = 0; cnt_e = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) cnt_d++;
      if (bus.busy) cnt_b++;
      if (bus.error) cnt_e++;
    end
    spurious = 1'b0;
    chk("midrst_done", cnt_d, 0);
    chk("midrst_busy_after", cnt_b, 0);
    chk("midrst_error", cnt_e, 0);
    chk("midrst_car", bus.car_out, 0);
    chk("midrst_cdr", bus.cdr_out, 0);
    m_car = '0; m_cdr = '0;

    // START held high: back-to-back fetches every six cycles.
    @(negedge clk);
    dly_car = 0; dly_cdr = 0; req_idx = 0;
    bus.start = 1'b1; bus.ptr_in = 12'h100;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 18) bus.start = 1'b0;
      if (bus.mem_req) b2b_req.push_back(c);
      if (bus.done) b2b_done.push_back(c);
    end
    chk("b2b_ndone", b2b_done.size(), 3);
    chk("b2b_nreq", b2b_req.size(), 6);
    for (int k = 0; k < b2b_done.size() && k < 3; k++) chk("b2b_done_cycle", b2b_done[k], 6 * k + 5);
    for (int k = 0; k < b2b_req.size() && k < 6; k++) chk("b2b_req_cycle", b2b_req[k], 6 * (k / 2) + 1 + 2 * (k % 2));
    @(negedge clk);
    chk("b2b_idle", bus.busy, 0);
    chk("b2b_car", bus.car_out, mem[12'h100]);
    chk("b2b_cdr", bus.cdr_out, mem[12'h101]);
    m_car = mem[12'h100]; m_cdr = mem[12'h101];

    // Randomized fetches, including NIL, wrap-around and delayed/silent memory.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0:       rp = 12'h000;
        1:       rp = 12'hFFF;
        default: rp = 12'($urandom);
      endcase
      run_fetch(rp, pick_dly(), pick_dly());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cell_fetch.md
CELL_FETCH -- requirements
Module: cell_fetch

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, maximum cycles waited for MEM_DATA_READY per word before abort.
REQ-002 CLK  input  1  sole clock; all logic on posedge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  fetch request; sampled only in IDLE.
REQ-005 PTR_IN  input  12  cons-cell pointer; car at PTR_IN, cdr at PTR_IN+1.
REQ-006 BUSY  output  1  high in every state except IDLE.
REQ-007 DONE  output  1  one-cycle completion pulse.
REQ-008 ERROR  output  1  one-cycle pulse, coincident with DONE, on timeout.
REQ-009 CAR_OUT  output  16  fetched car word.
REQ-010 CDR_OUT  output  16  fetched cdr word.
REQ-011 MEM_REQ  output  1  memory request; high for exactly one cycle per word.
REQ-012 MEM_ADDR  output  12  memory word address; valid while MEM_REQ is high.
REQ-013 MEM_DATA_READY  input  1  memory response strobe; arrives one cycle after MEM_REQ.
REQ-014 MEM_DATA  input  16  memory read data; valid while MEM_DATA_READY is high.

Function
REQ-015 States SHALL be IDLE, REQ_CAR, WAIT_CAR, REQ_CDR, WAIT_CDR, FINISH, and all outputs SHALL be registered.
REQ-016 In IDLE, START=1 with PTR_IN!=0 SHALL latch PTR_IN and go to REQ_CAR; START is ignored in every other state.
REQ-017 In IDLE, START=1 with PTR_IN==0 (NIL) SHALL go to FINISH with no MEM_REQ and CAR_OUT=CDR_OUT=0.
REQ-018 REQ_CAR SHALL drive MEM_REQ=1 with MEM_ADDR=latched pointer for one cycle, then go to WAIT_CAR.
REQ-019 In WAIT_CAR, MEM_DATA_READY=1 SHALL capture MEM_DATA into CAR_OUT and go to REQ_CDR.
REQ-020 REQ_CDR SHALL drive MEM_REQ=1 with MEM_ADDR=pointer+1 (12-bit, 0xFFF wraps to 0x000), then go to WAIT_CDR.
REQ-021 In WAIT_CDR, MEM_DATA_READY=1 SHALL capture MEM_DATA into CDR_OUT and go to FINISH.
REQ-022 FINISH SHALL assert DONE=1 for one cycle and return to IDLE; START is not accepted in FINISH.
REQ-023 Latency: with START sampled at edge 0, MEM_REQ is high in cycles 1 and 3, and DONE is high in cycle 5; a NIL fetch has DONE high in cycle 1.
REQ-024 A wait counter SHALL clear on entry to each WAIT state and increment every cycle that MEM_DATA_READY=0.
REQ-025 When the counter reaches TIMEOUT_CYCLES, the block SHALL go to FINISH with ERROR=1 alongside DONE.
REQ-026 On timeout, CAR_OUT and CDR_OUT SHALL keep their prior values, except any word already captured in the current fetch.
REQ-027 MEM_DATA_READY outside a WAIT state SHALL be ignored and SHALL NOT modify any output.
REQ-028 If MEM_DATA_READY arrives in the same cycle the counter hits the limit, the data SHALL win and no error is raised.
REQ-029 CAR_OUT and CDR_OUT SHALL hold stable between fetches.

Reset
REQ-030 RST=1 SHALL force IDLE, with BUSY=DONE=ERROR=MEM_REQ=0, MEM_ADDR=0, CAR_OUT=CDR_OUT=0 and the counter cleared, on the next edge.
REQ-031 RST asserted mid-fetch SHALL abort without a DONE pulse.
REQ-032 A MEM_DATA_READY arriving after reset SHALL be ignored per REQ-027.
REQ-033 RST SHALL take priority over START.

Structure
REQ-034 Package lisp_mem_pkg SHALL hold ADDR_W=12, DATA_W=16, NIL_PTR=12'h000 and the fetch_state_t enum.
REQ-035 No sub-module; single module with one state register, one counter and the output registers.

Verification
REQ-036 Memory model responds one cycle after REQ with MEM[0x010]=0x1234, MEM[0x011]=0xBEEF; START with PTR_IN=0x010 -> MEM_REQ in cycles 1 and 3 at addresses 0x010 and 0x011, DONE in cycle 5, CAR_OUT=0x1234, CDR_OUT=0xBEEF, ERROR=0.
REQ-037 START with PTR_IN=0x000 -> DONE in cycle 1, CAR_OUT=CDR_OUT=0, MEM_REQ never asserted.
REQ-038 PTR_IN=0xFFF with MEM[0xFFF]=0x00AA, MEM[0x000]=0x0000 -> second MEM_ADDR=0x000, CAR_OUT=0x00AA, CDR_OUT=0x0000.
REQ-039 Memory mute on the cdr read -> DONE=ERROR=1 exactly TIMEOUT_CYCLES cycles after WAIT_CDR entry, CAR_OUT updated, CDR_OUT unchanged.
REQ-040 RST pulsed in WAIT_CAR, then a late MEM_DATA_READY -> no DONE pulse, outputs stay 0, IDLE.
REQ-041 START held high continuously -> back-to-back fetches, one per 6 cycles, with START ignored while BUSY.
